instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Front-end stage of the RV32I core, directly upstream of decode and the immediate extender. It owns the PC, issues word fetches to instruction memory over a valid/ready request plus in-order response interface, and buffers returned words with their PCs in a small FIFO. It presents them to decode with a valid/ready handshake. Redirects come from next-PC logic (pc + extended immediate for BRANCH/JAL, rs1 + immediate for JALR); on a redirect it flushes buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.
FIFO_DEPTH, 2, instruction buffer entries; power of two, 2 or more.

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  fetch address, always equal to the current PC register
imem_rsp_valid  in  1  response word valid; one per accepted request, in order, latency 1 or more cycles
imem_rsp_data  in  32  fetched instruction word
redirect_valid  in  1  next-PC override from branch/jump resolution
redirect_pc  in  32  new fetch address
instr_valid  out  1  decode-side word valid
instr_ready  in  1  decode accepts word
instr  out  32  instruction word (FIFO head)
instr_pc  out  32  PC of instr
misaligned_fault  out  1  sticky: last redirect target had redirect_pc[1:0] != 0

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0; state=RUN.
  - Outputs: imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0, misaligned_fault=0.
  - Reset mid-operation discards all FIFO contents and in-flight responses; responses arriving after deassertion with outstanding=0 are ignored.
- States: RUN, FAULT.
- RUN to FAULT: redirect_valid with redirect_pc[1:0] != 0.
- FAULT to RUN: redirect_valid with an aligned redirect_pc.
- Any state to RUN: aligned redirect.
- Request issue:
  - imem_req_valid = (state==RUN) & !redirect_valid & (count + outstanding < FIFO_DEPTH).
  - count and outstanding are registered values; there is no same-cycle pop credit.
  - Fire = valid & ready. On fire: pc += 4 (wraps 32'hFFFF_FFFC to 0), outstanding += 1.
  - While valid and not ready, the address holds stable.
- Response:
  - Each rsp_valid with outstanding > 0 decrements outstanding.
  - If drop_cnt > 0: the word is discarded and drop_cnt decrements.
  - Otherwise the word is pushed with its PC; an internal pc_rsp register tracks the expected response PC.
  - Credit rule guarantees the FIFO never overflows; a push into a full FIFO is a design error and is asserted in simulation.
- Output:
  - instr_valid = FIFO non-empty; instr/instr_pc = head entry.
  - Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle leaves count unchanged.
  - Minimum latency: request fires cycle N, response cycle N+1, instr_valid cycle N+2.
- Redirect (redirect_valid=1), taking effect at the next edge:
  - FIFO flushed; any same-cycle pop or response is discarded.
  - drop_cnt <= outstanding - rsp_valid.
  - pc <= {redirect_pc[31:2], 2'b00}; pc_rsp <= same value.
  - No request fires in the redirect cycle.
  - Aligned target: misaligned_fault <= 0. Misaligned target: misaligned_fault <= 1, state FAULT, no requests issued; in-flight responses still drain into drop_cnt.
  - Back-to-back redirects: the last one wins.
- Counter widths: outstanding and drop_cnt are clog2(FIFO_DEPTH)+1 bits and never exceed FIFO_DEPTH.

Test Plan:
- Reset then steady fetch: RESET_PC=0, memory latency 1, instr_ready=1 -> request addresses 0, 4, 8, ...; first instr_valid on cycle 2 with instr_pc=0; instr matches the memory image word for word.
- Backpressure: instr_ready=0 for 10 cycles -> at most 2 requests issued, then imem_req_valid=0; both words held stable; releasing ready delivers PC 0 then 4 with none lost or duplicated.
- Redirect with in-flight fetch: memory latency 3, redirect to 0x100 while 2 requests are outstanding -> both stale responses dropped, next delivered instr_pc=0x100, FIFO empty on the cycle after redirect.
- Misaligned redirect to 0x102 -> misaligned_fault=1 next cycle, imem_req_valid stays 0; a later redirect to 0x200 clears the fault and the first delivered instr_pc=0x200.
- PC wrap: redirect to 0xFFFF_FFF8 -> delivered PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Async reset mid-stream (rst_n low for half a cycle with 2 outstanding) -> all outputs 0 immediately; after release, fetch restarts at RESET_PC and late responses are ignored.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Instruction fetch unit bus bundle: instruction-memory request/response,
// redirect input from next-PC logic, and the decode-side instruction stream.
//
// Handshake semantics (all valid/ready pairs in this bundle):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   Once valid is raised, the payload stays stable and valid stays high
//   until the transfer happens, unless a redirect or reset cancels it.
//   Ready may depend on valid, and valid never waits for ready.
//   imem_rsp_valid has no ready: memory returns exactly one word per
//   accepted request, in request order, at least one cycle later.
interface instruction_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misaligned_fault;

  // Fetch unit side
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready,
    output misaligned_fault
  );

  // Environment side: instruction memory, next-PC logic and decode
  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready,
    input  misaligned_fault
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// RV32I instruction fetch unit. Owns the PC, issues word fetches with a
// credit limit so the instruction FIFO can never overflow, tracks in-flight
// responses, and discards stale responses after a redirect via drop_cnt.
// state_dbg exposes the FSM state (0 = RUN, 1 = FAULT).
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  instruction_fetch_unit_if.master bus,
  output logic                     state_dbg
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_WIDE = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

  state_e        state;
  logic          misaligned_q;

  logic [31:0]   pc;
  logic [31:0]   pc_rsp;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;

  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          req_valid;
  logic          req_fire;
  logic          rsp_acc;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  logic          redir;
  logic          redir_bad;
  logic [31:0]   redir_tgt;
  logic [CW:0]   credit_used;

  // Redirect decode: the target is always word-aligned; low bits only flag a fault
  assign redir       = bus.redirect_valid;
  assign redir_bad   = (bus.redirect_pc[1:0] != 2'b00);
  assign redir_tgt   = {bus.redirect_pc[31:2], 2'b00};

  // Credit counts both buffered words and words still in memory, so every
  // accepted request is guaranteed a FIFO slot when its response returns
  assign credit_used = {1'b0, count} + {1'b0, outstanding};

  // rst_n gating keeps the request low while reset is asserted
  assign req_valid   = rst_n & (state == ST_RUN) & ~redir & (credit_used < DEPTH_WIDE);
  assign req_fire    = req_valid & bus.imem_req_ready;

  // Responses only count against requests that are actually outstanding;
  // anything arriving with outstanding==0 belongs to a pre-reset request
  assign rsp_acc     = bus.imem_rsp_valid & (outstanding != '0);
  assign rsp_drop    = rsp_acc & (drop_cnt != '0);
  assign push        = rsp_acc & (drop_cnt == '0) & ~redir;
  assign pop         = (count != '0) & bus.instr_ready & ~redir;

  assign bus.imem_req_valid   = req_valid;
  assign bus.imem_req_addr    = pc;
  assign bus.instr_valid      = (count != '0);
  assign bus.instr            = fifo_instr[rd_ptr];
  assign bus.instr_pc         = fifo_pc[rd_ptr];
  assign bus.misaligned_fault = misaligned_q;
  assign state_dbg            = (state == ST_FAULT);

  // FSM: any redirect picks the next state from its alignment; fault flag is sticky until then
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      misaligned_q <= 1'b0;
    end else if (redir) begin
      if (redir_bad) begin
        state        <= ST_FAULT;
        misaligned_q <= 1'b1;
      end else begin
        state        <= ST_RUN;
        misaligned_q <= 1'b0;
      end
    end
  end

  // PC, response PC and in-flight bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      pc_rsp      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redir) begin
      // No request fires this cycle, so only a returning response changes
      // the in-flight count; everything still in flight becomes stale
      pc          <= redir_tgt;
      pc_rsp      <= redir_tgt;
      outstanding <= outstanding - CW'(rsp_acc);
      drop_cnt    <= outstanding - CW'(rsp_acc);
    end else begin
      if (req_fire) begin
        pc <= pc + 32'd4;
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_acc);
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (push) begin
        pc_rsp <= pc_rsp + 32'd4;
      end
    end
  end

  // Instruction FIFO: push accepted responses, pop on decode handshake, flush on redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (redir) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_instr[wr_ptr] <= bus.imem_rsp_data;
        fifo_pc[wr_ptr]    <= pc_rsp;
        wr_ptr             <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The credit limit makes a push into a full FIFO impossible
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == DEPTH_CNT)));

  a_drop_bounded : assert property (@(posedge clk) disable iff (!rst_n)
    (drop_cnt <= DEPTH_CNT) && (outstanding <= DEPTH_CNT));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: behavioural instruction memory with
// programmable latency, directed phases pushing expected {pc, word} pairs,
// and a monitor that checks each decode-side handshake against the queue.
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic state_dbg;

  always #5 clk = ~clk;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks   = 0;
  int failures = 0;
  int lat      = 1;
  int fire_cnt = 0;
  int cyc      = 0;

  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction memory: in-order responses, each due lat cycles after its request fired
  always @(posedge clk) begin
    cyc++;
    if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
      pend_q.push_back('{addr: bus.imem_req_addr, due: cyc + lat - 1});
      fire_cnt++;
    end
    #1;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end
  end

  // Monitor: every decode handshake must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && bus.instr_valid && bus.instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_instr: got pc %h word %h, expected no delivery", bus.instr_pc, bus.instr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("instr_pc", bus.instr_pc, e[63:32]);
        check("instr_word", bus.instr, e[31:0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_pc(input logic [31:0] p);
    exp_q.push_back({p, mem_word(p)});
  endtask

  // Wait for the expected queue to empty, then stop accepting words
  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step(1);
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: got %0d undelivered words expected 0", name, exp_q.size());
      exp_q.delete();
    end
    bus.instr_ready = 1'b0;
  endtask

  task automatic wait_fires(input string name, input int target, input int budget);
    int k;
    k = 0;
    while (fire_cnt < target && k < budget) begin
      step(1);
      k++;
    end
    check(name, fire_cnt, target);
  endtask

  task automatic redirect(input logic [31:0] t);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = t;
    step(1);
    bus.redirect_valid = 1'b0;
  endtask

  // Directed stimulus
  initial begin
    int f0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.instr_ready    = 1'b0;

    // Reset values
    #2;
    check("rst_req_valid", bus.imem_req_valid, 0);
    check("rst_instr_valid", bus.instr_valid, 0);
    check("rst_instr", bus.instr, 0);
    check("rst_instr_pc", bus.instr_pc, 0);
    check("rst_fault", bus.misaligned_fault, 0);
    check("rst_state", state_dbg, 0);
    step(2);

    // Steady fetch from RESET_PC, latency 1
    for (int i = 0; i < 8; i++) expect_pc(32'h0 + 32'(i * 4));
    rst_n = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("c0_req_valid", bus.imem_req_valid, 1);
    check("c0_req_addr", bus.imem_req_addr, 32'h0);
    check("c0_instr_valid", bus.instr_valid, 0);
    step(1);
    @(negedge clk);
    check("c1_instr_valid", bus.instr_valid, 0);
    step(1);
    @(negedge clk);
    check("c2_instr_valid", bus.instr_valid, 1);
    drain("drain_steady", 100);

    // Backpressure: requests stop at the credit limit, head word holds
    f0 = fire_cnt;
    step(10);
    check("bp_fires_le2", 32'((fire_cnt - f0) <= 2), 1);
    @(negedge clk);
    check("bp_req_valid", bus.imem_req_valid, 0);
    check("bp_instr_valid", bus.instr_valid, 1);
    check("bp_head_pc", bus.instr_pc, 32'h20);
    check("bp_head_word", bus.instr, mem_word(32'h20));
    step(3);
    @(negedge clk);
    check("bp_head_pc_stable", bus.instr_pc, 32'h20);
    step(1);
    for (int i = 0; i < 4; i++) expect_pc(32'h20 + 32'(i * 4));
    bus.instr_ready = 1'b1;
    drain("drain_bp", 100);

    // Redirect with two requests in flight, latency 3
    lat = 3;
    redirect(32'h80);
    f0 = fire_cnt;
    wait_fires("inflight_fires", f0 + 2, 20);
    check("inflight_pending", pend_q.size(), 2);
    redirect(32'h100);
    @(negedge clk);
    check("flush_instr_valid", bus.instr_valid, 0);
    step(1);
    for (int i = 0; i < 4; i++) expect_pc(32'h100 + 32'(i * 4));
    bus.instr_ready = 1'b1;
    drain("drain_redirect", 100);

    // Misaligned redirect then recovery
    lat = 1;
    redirect(32'h102);
    @(negedge clk);
    check("mis_fault", bus.misaligned_fault, 1);
    check("mis_state", state_dbg, 1);
    check("mis_req_valid", bus.imem_req_valid, 0);
    f0 = fire_cnt;
    step(5);
    @(negedge clk);
    check("mis_no_fires", fire_cnt, f0);
    check("mis_req_valid_hold", bus.imem_req_valid, 0);
    step(1);
    redirect(32'h200);
    @(negedge clk);
    check("clr_fault", bus.misaligned_fault, 0);
    check("clr_state", state_dbg, 0);
    step(1);
    for (int i = 0; i < 3; i++) expect_pc(32'h200 + 32'(i * 4));
    bus.instr_ready = 1'b1;
    drain("drain_recover", 100);

    // PC wrap
    redirect(32'hFFFF_FFF8);
    expect_pc(32'hFFFF_FFF8);
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0000_0000);
    bus.instr_ready = 1'b1;
    drain("drain_wrap", 100);

    // Async reset with two requests in flight
    lat = 3;
    redirect(32'h300);
    f0 = fire_cnt;
    wait_fires("rst_inflight_fires", f0 + 2, 20);
    bus.imem_req_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_req_valid", bus.imem_req_valid, 0);
    check("arst_instr_valid", bus.instr_valid, 0);
    check("arst_instr", bus.instr, 0);
    check("arst_instr_pc", bus.instr_pc, 0);
    check("arst_fault", bus.misaligned_fault, 0);
    #3;
    rst_n = 1'b1;
    step(6);
    @(negedge clk);
    check("post_rst_instr_valid", bus.instr_valid, 0);
    check("post_rst_req_valid", bus.imem_req_valid, 1);
    check("post_rst_req_addr", bus.imem_req_addr, 32'h0);
    step(1);
    lat = 1;
    expect_pc(32'h0);
    expect_pc(32'h4);
    expect_pc(32'h8);
    bus.imem_req_ready = 1'b1;
    bus.instr_ready = 1'b1;
    drain("drain_post_rst", 100);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
